xsm_channel_scanner: RTL and testbench

- Producer side of the XSM sensor interface: sequences an external ADC/sensor front-end round-robin over 12 channels.
- Drives the per-channel xsm_valid / xsm_data bus consumed by the XENOS boundary checker.
- Owns scan timing, the req/ack conversion handshake, per-channel timeout detection and data freshness. A channel that fails to convert is never presented as valid.

---
 rtl/xsm_channel_scanner.sv | 183 ++++++++++++++++++
 tb/tb_xsm_channel_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/xsm_channel_scanner.sv
// xsm_channel_scanner
// Producer side of the XSM sensor interface. Steps an external ADC front-end
// round-robin over the enabled channels. There is one req/ack conversion in
// flight at a time, and each wait is bounded by ACK_TIMEOUT. The scanner
// publishes a fresh-sample bus per channel (xsm_valid / xsm_data).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   scan_en             periodic scanning every SCAN_PERIOD cycles
//   scan_start          one-cycle request for an immediate scan
//   ch_enable           channel mask, latched when a scan starts
//   adc_req/adc_chan    conversion request and channel (chan stable while req)
//   adc_ack/adc_data    conversion complete + result
//   xsm_valid/xsm_data  per-channel freshness flag and last sample (flat, ch0 in LSBs)
//   scan_busy           high in every state except IDLE
//   scan_done           one-cycle pulse at the end of a scan
//   scan_overrun        one-cycle pulse when a trigger arrives while busy
//   timeout_flags       last attempt on the channel timed out
//   timeout_count       saturating total of timeouts

// Per-channel sample/status storage. Capture has priority over timeout, and
// timeout has priority over the scan-start clear. Only one of these strobes
// is active per cycle anyway.
module xsm_scanner_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              cap,
  input  logic              tmo,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic              tflag,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tflag <= 1'b0;
      data  <= '0;
    end else if (cap) begin
      valid <= 1'b1;
      tflag <= 1'b0;
      data  <= din;
    end else if (tmo) begin
      valid <= 1'b0;   // stale data is kept but no longer advertised
      tflag <= 1'b1;
    end else if (clr) begin
      valid <= 1'b0;
      tflag <= 1'b0;
    end
  end
endmodule

module xsm_channel_scanner #(
  parameter int NUM_CH      = 12,
  parameter int DATA_W      = 32,
  parameter int SCAN_PERIOD = 1000,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     scan_en,
  input  logic                     scan_start,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic                     adc_req,
  output logic [3:0]               adc_chan,
  input  logic                     adc_ack,
  input  logic [DATA_W-1:0]        adc_data,
  output logic [NUM_CH-1:0]        xsm_valid,
  output logic [NUM_CH*DATA_W-1:0] xsm_data,
  output logic                     scan_busy,
  output logic                     scan_done,
  output logic                     scan_overrun,
  output logic [NUM_CH-1:0]        timeout_flags,
  output logic [7:0]               timeout_count
);
  localparam int PC_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
  localparam int WC_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SELECT, REQ, DONE} state_t;

  state_t            state;
  logic [PC_W-1:0]   per_cnt;
  logic [NUM_CH-1:0] en_q;
  logic [4:0]        ptr;       // one wider than a channel index so ch+1 can run past the last channel
  logic [WC_W-1:0]   wait_cnt;
  logic              tick, trigger, start, ack_ok, tmo_hit, found;
  logic [3:0]        sel_ch;

  // Period counter: free-runs only while scan_en is set.
  assign tick = scan_en && (per_cnt == PC_W'(SCAN_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        per_cnt <= '0;
    else if (!scan_en) per_cnt <= '0;
    else if (tick)     per_cnt <= '0;
    else               per_cnt <= per_cnt + 1'b1;
  end

  assign trigger = tick | scan_start;
  assign start   = (state == IDLE) && trigger;
  assign ack_ok  = (state == REQ) && adc_req && adc_ack;
  // Timeout fires on the cycle in which the wait count reaches ACK_TIMEOUT.
  // A same-cycle ack wins.
  assign tmo_hit = (state == REQ) && adc_req && !adc_ack &&
                   (wait_cnt == WC_W'(ACK_TIMEOUT - 1));

  // Lowest enabled channel at or above the pointer. The loop runs downward so
  // that the last assignment is the lowest index.
  always_comb begin
    found  = 1'b0;
    sel_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en_q[i] && (5'(i) >= ptr)) begin
        found  = 1'b1;
        sel_ch = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      en_q          <= '0;
      ptr           <= '0;
      wait_cnt      <= '0;
      adc_req       <= 1'b0;
      adc_chan      <= '0;
      scan_done     <= 1'b0;
      scan_overrun  <= 1'b0;
      timeout_count <= '0;
    end else begin
      scan_done    <= 1'b0;
      scan_overrun <= trigger && (state != IDLE);
      case (state)
        IDLE: if (trigger) begin
          en_q  <= ch_enable;
          ptr   <= '0;
          state <= SELECT;
        end
        SELECT: if (found) begin
          adc_chan <= sel_ch;
          adc_req  <= 1'b1;
          wait_cnt <= '0;
          state    <= REQ;
        end else begin
          scan_done <= 1'b1;   // scan_done is high for exactly the DONE cycle
          state     <= DONE;
        end
        REQ: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (ack_ok || tmo_hit) begin
            adc_req <= 1'b0;
            ptr     <= 5'(adc_chan) + 5'd1;
            state   <= SELECT;
          end
          if (tmo_hit && timeout_count != 8'hFF)
            timeout_count <= timeout_count + 8'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign scan_busy = (state != IDLE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    xsm_scanner_lane #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start && !ch_enable[i]),
      .cap   (ack_ok && (adc_chan == 4'(i))),
      .tmo   (tmo_hit && (adc_chan == 4'(i))),
      .din   (adc_data),
      .valid (xsm_valid[i]),
      .tflag (timeout_flags[i]),
      .data  (xsm_data[i*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_xsm_channel_scanner.sv
module tb_xsm_channel_scanner;
  localparam int NUM_CH = 12, DATA_W = 32, SCAN_PERIOD = 20, ACK_TIMEOUT = 64;

  logic                     clk = 1'b0, rst_n = 1'b0, scan_en = 1'b0, scan_start = 1'b0;
  logic [NUM_CH-1:0]        ch_enable = '0;
  logic                     adc_req, adc_ack;
  logic [3:0]               adc_chan;
  logic [DATA_W-1:0]        adc_data;
  logic [NUM_CH-1:0]        xsm_valid, timeout_flags;
  logic [NUM_CH*DATA_W-1:0] xsm_data;
  logic                     scan_busy, scan_done, scan_overrun;
  logic [7:0]               timeout_count;

  xsm_channel_scanner #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SCAN_PERIOD(SCAN_PERIOD),
                        .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .scan_start(scan_start),
    .ch_enable(ch_enable), .adc_req(adc_req), .adc_chan(adc_chan), .adc_ack(adc_ack),
    .adc_data(adc_data), .xsm_valid(xsm_valid), .xsm_data(xsm_data),
    .scan_busy(scan_busy), .scan_done(scan_done), .scan_overrun(scan_overrun),
    .timeout_flags(timeout_flags), .timeout_count(timeout_count));

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] valid;
    logic [11:0] tflags;
    logic [7:0]  tcount;
    logic        chk_d;
    int          dch;
    logic [31:0] ddata;
  } done_t;

  done_t exp_done[$];
  int    exp_chan[$];
  int    checks = 0, failures = 0;
  int    req_rises = 0, done_seen = 0, ovr_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ADC front-end model: acks ack_delay cycles after seeing req, except for
  // channels in noack; late_ack forces a stray ack pulse.
  int          ack_delay = 3;
  logic [11:0] noack = '0;
  logic [31:0] data_base = 32'h100;
  int          ovr_ch = 15;
  logic [31:0] ovr_data = '0;
  logic        late_ack = 1'b0;

  initial begin
    int wcnt;
    wcnt = 0; adc_ack = 1'b0; adc_data = '0;
    forever begin
      @(negedge clk);
      adc_ack = 1'b0;
      if (late_ack) begin
        adc_ack = 1'b1; adc_data = 32'hBAD;
      end else if (!adc_req) begin
        wcnt = 0;
      end else begin
        wcnt++;
        if (wcnt == ack_delay && !noack[adc_chan]) begin
          adc_ack  = 1'b1;
          adc_data = (int'(adc_chan) == ovr_ch) ? ovr_data : data_base + 32'(adc_chan);
        end
      end
    end
  end

  // Monitor: checks each new request against the expected channel order, and
  // checks each scan_done against the expected end-of-scan state.
  logic  req_q = 1'b0;
  done_t d;
  always @(negedge clk) begin
    if (rst_n) begin
      if (adc_req && !req_q) begin
        req_rises++;
        if (exp_chan.size() == 0) chk("unexpected_req", 64'(adc_chan), 64'hFF);
        else chk("adc_chan", 64'(adc_chan), 64'(exp_chan.pop_front()));
      end
      if (scan_done) begin
        done_seen++;
        if (exp_done.size() == 0) chk("unexpected_done", 64'(done_seen), 0);
        else begin
          d = exp_done.pop_front();
          chk("done_valid", 64'(xsm_valid), 64'(d.valid));
          chk("done_tflags", 64'(timeout_flags), 64'(d.tflags));
          chk("done_tcount", 64'(timeout_count), 64'(d.tcount));
          if (d.chk_d) chk("done_data", 64'(xsm_data[d.dch*DATA_W +: DATA_W]), 64'(d.ddata));
        end
      end
      if (scan_overrun) ovr_seen++;
    end
    req_q = adc_req;
  end

  task automatic push_seq(input logic [11:0] m);
    for (int c = 0; c < NUM_CH; c++) if (m[c]) exp_chan.push_back(c);
  endtask

  task automatic push_done(input logic [11:0] v, input logic [11:0] f, input logic [7:0] n,
                           input logic cd, input int ch, input logic [31:0] dv);
    done_t e;
    e.valid = v; e.tflags = f; e.tcount = n; e.chk_d = cd; e.dch = ch; e.ddata = dv;
    exp_done.push_back(e);
  endtask

  task automatic start_scan(input logic [11:0] m);
    @(negedge clk); ch_enable = m; scan_start = 1'b1;
    @(negedge clk); scan_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0, c = 0;
    while (k < n && c < budget) begin
      @(negedge clk); c++;
      if (scan_done) k++;
    end
    chk("done_wait", 64'(k), 64'(n));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 64'(adc_req), 0);
    chk({tag, "_chan"}, 64'(adc_chan), 0);
    chk({tag, "_valid"}, 64'(xsm_valid), 0);
    chk({tag, "_data"}, 64'(xsm_data != '0), 0);
    chk({tag, "_busy"}, 64'(scan_busy), 0);
    chk({tag, "_done"}, 64'(scan_done), 0);
    chk({tag, "_ovr"}, 64'(scan_overrun), 0);
    chk({tag, "_tflags"}, 64'(timeout_flags), 0);
    chk({tag, "_tcount"}, 64'(timeout_count), 0);
  endtask

  initial begin
    int c, hi, rr;
    #12 check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Full mask, prompt acks
    push_seq(12'hFFF); push_done(12'hFFF, 12'h000, 8'd0, 1'b1, 5, 32'h105);
    start_scan(12'hFFF);
    wait_done(1, 500);
    @(negedge clk); @(negedge clk);
    chk("t1_busy_after", 64'(scan_busy), 0);
    chk("t1_done_once", 64'(done_seen), 1);

    // Sparse mask: disabled valid bits cleared at start, old data kept
    push_seq(12'h0A5); push_done(12'h0A5, 12'h000, 8'd0, 1'b1, 1, 32'h101);
    start_scan(12'h0A5);
    chk("t2_valid_at_start", 64'(xsm_valid), 64'h0A5);
    wait_done(1, 500);

    // Channel 3 never acks
    noack = 12'h008; data_base = 32'h200;
    push_seq(12'hFFF); push_done(12'hFF7, 12'h008, 8'd1, 1'b1, 3, 32'h103);
    start_scan(12'hFFF);
    c = 0;
    while (!(adc_req && adc_chan == 4'd3) && c < 500) begin @(negedge clk); c++; end
    hi = 0;
    while (adc_req && adc_chan == 4'd3 && hi < 200) begin hi++; @(negedge clk); end
    chk("t3_req_high_cycles", 64'(hi), 64'(ACK_TIMEOUT));
    wait_done(1, 1000);

    // Channel 3 recovers with 0xDEAD
    noack = '0; data_base = 32'h100; ovr_ch = 3; ovr_data = 32'hDEAD;
    push_seq(12'hFFF); push_done(12'hFFF, 12'h000, 8'd1, 1'b1, 3, 32'hDEAD);
    start_scan(12'hFFF);
    wait_done(1, 500);
    ovr_ch = 15;

    // Periodic scans that outlast the period
    chk("no_overrun_yet", 64'(ovr_seen), 0);
    ack_delay = 15; data_base = 32'h300;
    for (int k = 0; k < 3; k++) begin
      push_seq(12'h003); push_done(12'h003, 12'h000, 8'd1, 1'b1, 1, 32'h301);
    end
    @(negedge clk); ch_enable = 12'h003; scan_en = 1'b1;
    wait_done(3, 400);
    scan_en = 1'b0;
    chk("t5_overrun_seen", 64'(ovr_seen > 0), 1);
    ack_delay = 3;

    // 300 timeouts: counter saturates
    noack = 12'hFFF;
    for (int k = 1; k <= 25; k++) begin
      push_seq(12'hFFF);
      push_done(12'h000, 12'hFFF, (1 + 12*k > 255) ? 8'd255 : 8'(1 + 12*k), 1'b1, 0, 32'h300);
      start_scan(12'hFFF);
      wait_done(1, 2000);
    end

    // Empty mask
    noack = '0; rr = req_rises;
    push_done(12'h000, 12'h000, 8'd255, 1'b0, 0, 0);
    start_scan(12'h000);
    wait_done(1, 50);
    chk("t7_no_req", 64'(req_rises), 64'(rr));

    // Reset during REQ, then a stray ack
    noack = 12'h001;
    push_seq(12'h001);
    start_scan(12'h001);
    c = 0;
    while (!adc_req && c < 50) begin @(negedge clk); c++; end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); late_ack = 1'b1;
    repeat (2) @(negedge clk); late_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_ack_valid", 64'(xsm_valid), 0);
    chk("late_ack_data", 64'(xsm_data != '0), 0);
    chk("late_ack_req", 64'(adc_req), 0);

    chk("chan_queue_empty", 64'(exp_chan.size()), 0);
    chk("done_queue_empty", 64'(exp_done.size()), 0);
    chk("done_total", 64'(done_seen), 33);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
